// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a Moore FSM whose datapath controls decode
// from the current state; Zero and Function only refine BEQ and REXEC outputs.
module multicycle_control #(
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Function,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       PCSource,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       PCSel,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUCtrl,
  output logic       illegal,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  state_t state_q, state_d;

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    IRWrite  = 1'b0;
    PCSource = 1'b0;
    ALUSrcA  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    PCSel    = 1'b0;
    ALUSrcB  = 2'b00;
    ALUCtrl  = 4'b0010;
    illegal  = 1'b0;
    halted   = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCSel   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU computes PC+1+imm now so BEQ can take the target from ALUOut
        ALUSrcB = 2'b10;
        case (Op)
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h00:        state_d = S_REXEC;
          6'h04:        state_d = S_BEQ;
          6'h08, 6'h0A: state_d = S_IEXEC;
          default: begin
            if (Op == HALT_OP) begin
              state_d = S_HALT;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == 6'h23) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = S_FETCH;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        state_d = S_RWB;
        case (Function)
          6'h20: ALUCtrl = 4'b0010;
          6'h22: ALUCtrl = 4'b0110;
          6'h24: ALUCtrl = 4'b0000;
          6'h25: ALUCtrl = 4'b0001;
          6'h27: ALUCtrl = 4'b1100;
          6'h2A: ALUCtrl = 4'b0111;
          default: begin
            // unknown funct: drop the instruction without writing back
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA  = 1'b1;
        ALUCtrl  = 4'b0110;
        PCSource = 1'b1;
        PCSel    = Zero;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCtrl = (Op == 6'h0A) ? 4'b0111 : 4'b0010;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every side effect, whatever state the register holds.
    if (reset) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      PCSel    = 1'b0;
      illegal  = 1'b0;
      halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected per-cycle output vectors are
// queued from a table of the required state behaviour and compared each cycle.
module tb_multicycle_control;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7,
                         BEQ = 4'd8, IEXEC = 4'd9, IWB = 4'd10, HALT = 4'd11;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Function;
  logic       Zero;
  logic       IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource;
  logic       ALUSrcA, RegWrite, RegDst, PCSel, illegal, halted;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUCtrl;
  logic [3:0] state;

  multicycle_control #(.HALT_OP(6'h3F)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSel(PCSel), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
    .illegal(illegal), .halted(halted), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA,
  //  RegWrite, RegDst, PCSel, ALUSrcB, ALUCtrl, illegal, halted}
  logic [21:0] obs;
  assign obs = {state, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA,
                RegWrite, RegDst, PCSel, ALUSrcB, ALUCtrl, illegal, halted};

  logic [21:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int rw_conflict = 0;
  int we_conflict = 0;
  int mw_in_window = 0;
  bit sw_window = 1'b0;

  always @(negedge clk) begin
    if (MemRead && MemWrite) rw_conflict++;
    if (({1'b0, IRWrite} + {1'b0, RegWrite} + {1'b0, MemWrite}) > 2'd1) we_conflict++;
    if (sw_window && MemWrite) mw_in_window++;
  end

  function automatic bit fn_known(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) ||
           (f == 6'h25) || (f == 6'h27) || (f == 6'h2A);
  endfunction

  // Required outputs for a state, from the state table of the control unit.
  function automatic logic [21:0] spec_out(input logic [3:0] st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z,
                                           input logic rst);
    logic iord, mrd, mwr, m2r, irw, pcs, sra, rgw, rgd, pcl, ill, hlt;
    logic [1:0] srb;
    logic [3:0] alu;
    {iord, mrd, mwr, m2r, irw, pcs, sra, rgw, rgd, pcl, ill, hlt} = '0;
    srb = 2'b00;
    alu = 4'b0010;
    case (st)
      FETCH:  begin mrd = 1; irw = 1; srb = 2'b01; pcl = 1; end
      DECODE: begin
        srb = 2'b10;
        if (!(op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h0A, 6'h3F})) ill = 1;
      end
      MEMADR: begin sra = 1; srb = 2'b10; end
      MEMRD:  begin mrd = 1; iord = 1; end
      MEMWB:  begin rgw = 1; m2r = 1; end
      MEMWR:  begin mwr = 1; iord = 1; end
      REXEC:  begin
        sra = 1;
        case (fn)
          6'h22: alu = 4'b0110;
          6'h24: alu = 4'b0000;
          6'h25: alu = 4'b0001;
          6'h27: alu = 4'b1100;
          6'h2A: alu = 4'b0111;
          6'h20: alu = 4'b0010;
          default: ill = 1;
        endcase
      end
      RWB:    begin rgw = 1; rgd = 1; end
      BEQ:    begin sra = 1; alu = 4'b0110; pcs = 1; pcl = z; end
      IEXEC:  begin sra = 1; srb = 2'b10; alu = (op == 6'h0A) ? 4'b0111 : 4'b0010; end
      IWB:    rgw = 1;
      HALT:   hlt = 1;
      default: ;
    endcase
    if (rst) {mrd, mwr, irw, rgw, pcl, ill, hlt} = '0;
    return {st, iord, mrd, mwr, m2r, irw, pcs, sra, rgw, rgd, pcl, srb, alu, ill, hlt};
  endfunction

  task automatic push(input logic [3:0] st);
    exp_q.push_back(spec_out(st, Op, Function, Zero, reset));
  endtask

  task automatic check(input string tag, input logic [21:0] o, input logic [21:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Scoreboard drain: one queued vector per cycle, sampled mid-cycle.
  task automatic run_all(input string tag);
    logic [21:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, obs, e);
      @(posedge clk);
      #1;
    end
  endtask

  // Driver: present one instruction and queue its required state walk.
  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic z);
    Op = op;
    Function = fn;
    Zero = z;
    push(FETCH);
    push(DECODE);
    case (op)
      6'h23: begin push(MEMADR); push(MEMRD); push(MEMWB); end
      6'h2B: begin push(MEMADR); push(MEMWR); end
      6'h00: begin push(REXEC); if (fn_known(fn)) push(RWB); end
      6'h04: push(BEQ);
      6'h08, 6'h0A: begin push(IEXEC); push(IWB); end
      6'h3F: push(HALT);
      default: ;
    endcase
    run_all(tag);
  endtask

  logic [5:0] op_tab[6];
  logic [5:0] fn_tab[6];

  initial begin
    op_tab = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h0A};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    reset = 1'b1;
    Op = 6'h23;
    Function = 6'h00;
    Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(FETCH);
    run_all("reset_hold");
    reset = 1'b0;

    do_instr("lw", 6'h23, 6'(32'($urandom_range(0, 63))), 1'($urandom_range(0, 1)));
    do_instr("sw", 6'h2B, 6'h00, 1'($urandom_range(0, 1)));
    do_instr("r_slt", 6'h00, 6'h2A, 1'($urandom_range(0, 1)));
    do_instr("r_sub", 6'h00, 6'h22, 1'b0);
    do_instr("r_nor", 6'h00, 6'h27, 1'b1);
    do_instr("r_bad_fn", 6'h00, 6'h3F, 1'b0);
    do_instr("beq_taken", 6'h04, 6'h00, 1'b1);
    do_instr("beq_not_taken", 6'h04, 6'h00, 1'b0);
    do_instr("addi", 6'h08, 6'h2A, 1'b0);
    do_instr("slti", 6'h0A, 6'h20, 1'b1);
    do_instr("bad_op", 6'h11, 6'h20, 1'b0);

    // sw interrupted by reset while in MEMADR
    Op = 6'h2B;
    Function = 6'h20;
    push(FETCH);
    push(DECODE);
    run_all("sw_abort_pre");
    sw_window = 1'b1;
    reset = 1'b1;
    push(MEMADR);
    push(FETCH);
    run_all("sw_abort_rst");
    reset = 1'b0;
    push(FETCH);
    run_all("sw_abort_refetch");
    sw_window = 1'b0;
    push(DECODE);
    push(MEMADR);
    push(MEMWR);
    run_all("sw_after_abort");
    total++;
    assert (mw_in_window == 0) else begin
      bad++;
      $error("FAIL sw_abort_memwrite observed=%0d expected=0", mw_in_window);
    end

    for (int i = 0; i < 8; i++) begin
      int k;
      k = int'($urandom_range(0, 5));
      do_instr("random_mix", op_tab[k], fn_tab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
    end

    // HALT holds regardless of inputs until reset
    do_instr("halt_enter", 6'h3F, 6'h00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      Op = op_tab[$urandom_range(0, 5)];
      Zero = 1'($urandom_range(0, 1));
      push(HALT);
      run_all("halt_hold");
    end
    reset = 1'b1;
    push(HALT);
    push(FETCH);
    run_all("halt_reset");
    reset = 1'b0;
    do_instr("after_halt", 6'h08, 6'h00, 1'b0);

    total++;
    assert (rw_conflict == 0) else begin
      bad++;
      $error("FAIL memread_memwrite_overlap observed=%0d expected=0", rw_conflict);
    end
    total++;
    assert (we_conflict == 0) else begin
      bad++;
      $error("FAIL write_enable_overlap observed=%0d expected=0", we_conflict);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
